// File: rtl/act_ctrl_pkg.sv
// Shared definitions for the ACT-unit pass controllers: word geometry,
// datapath/FIFO defaults and the pass FSM encoding.
package act_ctrl_pkg;

    localparam int MAX_DAT_DW     = 16;
    localparam int TOUT           = 4;
    localparam int GELU_LAT_DEF   = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pass_state_t;

endpackage

// File: rtl/gelu_res_fifo.sv
// Result FIFO: a storage array with registered read feeding a registered
// head stage, so dout/empty come straight from flops.
module gelu_res_fifo #(
    parameter int DAT_W = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [DAT_W-1:0] din,
    input  logic             pop,
    output logic [DAT_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] mem_cnt_reg, total_reg;
    logic             out_vld_reg;
    logic [DAT_W-1:0] out_data_reg;

    logic pop_ok, push_ok, out_load, mem_has, bypass, mem_wr, mem_rd;

    assign full  = (total_reg == CNT_W'(DEPTH));
    assign empty = !out_vld_reg;
    assign dout  = out_data_reg;

    assign pop_ok   = pop && out_vld_reg;
    assign push_ok  = push && (!full || pop_ok);
    assign out_load = !out_vld_reg || pop_ok;
    assign mem_has  = (mem_cnt_reg != '0);
    // With nothing queued behind the head, a push lands directly in the head stage.
    assign bypass   = push_ok && out_load && !mem_has;
    assign mem_wr   = push_ok && !bypass;
    assign mem_rd   = out_load && mem_has;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            mem_cnt_reg  <= '0;
            total_reg    <= '0;
            out_vld_reg  <= 1'b0;
            out_data_reg <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (mem_rd) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            mem_cnt_reg <= mem_cnt_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
            total_reg   <= total_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (out_load) begin
                out_vld_reg <= mem_has || push_ok;
                if (mem_rd) begin
                    out_data_reg <= mem[rd_ptr_reg];
                end else if (bypass) begin
                    out_data_reg <= din;
                end
            end
        end
    end

endmodule

// File: rtl/gelu_pass_ctrl.sv
// Sequencer for one GELU pass: credit-limited reads into the fixed-latency
// datapath, results captured in a FIFO and written out under backpressure.
module gelu_pass_ctrl
    import act_ctrl_pkg::*;
#(
    parameter int DAT_W      = MAX_DAT_DW * TOUT,
    parameter int ADDR_W     = 16,
    parameter int GELU_LAT   = GELU_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [2:0]        cfg_scale,
    input  logic              cfg_gelu,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DAT_W-1:0]  rd_data,
    output logic              act_gelu,
    output logic [2:0]        act_scale,
    output logic [DAT_W-1:0]  act_dat_in,
    output logic              act_in_vld,
    input  logic [DAT_W-1:0]  act_dat_out,
    input  logic              act_out_vld,
    output logic              wr_vld,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DAT_W-1:0]  wr_data,
    input  logic              wr_rdy
);

    localparam int                CRED_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

    if ((FIFO_DEPTH < GELU_LAT + 3) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("gelu_pass_ctrl: FIFO_DEPTH must be a power of 2 and >= GELU_LAT+3");
    end

    pass_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] src_base_reg, dst_base_reg, len_reg;
    logic [ADDR_W-1:0] issued_reg, written_reg;
    logic [2:0]        scale_reg;
    logic              gelu_reg;
    logic [CRED_W-1:0] credit_reg;
    logic              in_vld_reg;
    logic              err_reg;

    logic              issue, pop, push, latch_cfg;
    logic              fifo_full, fifo_empty;
    logic [DAT_W-1:0]  fifo_head;

    assign pop  = !fifo_empty && wr_rdy;
    // Results arriving while idle (e.g. still in flight across a reset) are discarded.
    assign push = act_out_vld && (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        latch_cfg  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    latch_cfg = 1'b1;
                    // An empty pass takes one DRAIN cycle so busy spans two cycles.
                    state_next = (cfg_len == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                issue = (issued_reg < len_reg) && (credit_reg != '0);
                if (issue && (issued_reg + ADDR_ONE == len_reg)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((written_reg == len_reg) || (pop && (written_reg + ADDR_ONE == len_reg))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            src_base_reg <= '0;
            dst_base_reg <= '0;
            len_reg      <= '0;
            scale_reg    <= '0;
            gelu_reg     <= 1'b0;
            issued_reg   <= '0;
            written_reg  <= '0;
            credit_reg   <= '0;
            in_vld_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            in_vld_reg <= issue;
            err_reg    <= err_reg || (push && fifo_full && !pop);
            if (latch_cfg) begin
                src_base_reg <= cfg_src_base;
                dst_base_reg <= cfg_dst_base;
                len_reg      <= cfg_len;
                scale_reg    <= cfg_scale;
                gelu_reg     <= cfg_gelu;
                issued_reg   <= '0;
                written_reg  <= '0;
                credit_reg   <= CRED_FULL;
            end else begin
                if (issue) begin
                    issued_reg <= issued_reg + ADDR_ONE;
                end
                if (pop) begin
                    written_reg <= written_reg + ADDR_ONE;
                end
                case ({issue, pop})
                    2'b10:   credit_reg <= credit_reg - CRED_W'(1);
                    2'b01:   credit_reg <= credit_reg + CRED_W'(1);
                    default: credit_reg <= credit_reg;
                endcase
            end
        end
    end

    gelu_res_fifo #(
        .DAT_W (DAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (act_dat_out),
        .pop   (pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign err        = err_reg;
    assign rd_en      = issue;
    assign rd_addr    = src_base_reg + issued_reg;
    assign act_gelu   = gelu_reg;
    assign act_scale  = scale_reg;
    assign act_in_vld = in_vld_reg;
    assign act_dat_in = in_vld_reg ? rd_data : '0;
    assign wr_vld     = !fifo_empty;
    assign wr_addr    = dst_base_reg + written_reg;
    assign wr_data    = fifo_head;

endmodule

// File: tb/tb_gelu_pass_ctrl.sv
// Directed bench for gelu_pass_ctrl with a source-buffer model and a
// fixed-latency datapath model; vector table plus corner-case sequences.
module tb_gelu_pass_ctrl;

    localparam int DAT_W  = 64;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] cfg_src_base, cfg_dst_base, cfg_len;
    logic [2:0]        cfg_scale;
    logic              cfg_gelu;
    logic              busy, done, err, rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DAT_W-1:0]  rd_data = '0;
    logic              act_gelu;
    logic [2:0]        act_scale;
    logic [DAT_W-1:0]  act_dat_in;
    logic              act_in_vld;
    logic [DAT_W-1:0]  act_dat_out;
    logic              act_out_vld;
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [DAT_W-1:0]  wr_data;
    logic              wr_rdy;

    gelu_pass_ctrl #(
        .DAT_W      (DAT_W),
        .ADDR_W     (ADDR_W),
        .GELU_LAT   (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_len      (cfg_len),
        .cfg_scale    (cfg_scale),
        .cfg_gelu     (cfg_gelu),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .act_gelu     (act_gelu),
        .act_scale    (act_scale),
        .act_dat_in   (act_dat_in),
        .act_in_vld   (act_in_vld),
        .act_dat_out  (act_dat_out),
        .act_out_vld  (act_out_vld),
        .wr_vld       (wr_vld),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mkword(logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, 16'hC3C3};
    endfunction

    function automatic logic [63:0] xform(logic [63:0] d, logic [2:0] s, logic g);
        return g ? (d + {61'd0, s}) : ~d;
    endfunction

    // Source buffer: one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= mkword(rd_addr);

    // Datapath: fixed latency model_lat, plus an injection override for overflow tests.
    int               model_lat = 4;
    logic             inject_vld = 1'b0;
    logic [15:0]      pv = '0;
    logic [63:0]      pd [16];
    always @(posedge clk) begin
        pv    <= {pv[14:0], act_in_vld};
        pd[0] <= xform(act_dat_in, act_scale, act_gelu);
        for (int i = 1; i < 16; i++) pd[i] <= pd[i-1];
    end
    assign act_out_vld = pv[model_lat-1] | inject_vld;
    assign act_dat_out = inject_vld ? 64'hDEAD_BEEF_0000_0001 : pd[model_lat-1];

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    ev_t         rd_q[$];
    ev_t         wr_q[$];
    int          t0 = 0;
    int          done_cnt, done_cyc, busy_cnt, hold_samples, hold_viol;
    bit          err_seen;
    int          checks = 0;
    int          failures = 0;

    initial begin
        bit          prev_stall;
        logic [15:0] prev_addr;
        logic [63:0] prev_data;
        int          rel;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (rd_en) rd_q.push_back('{rd_addr, 64'h0, rel});
            if (wr_vld && wr_rdy) wr_q.push_back('{wr_addr, wr_data, rel});
            if (done) begin
                done_cnt++;
                done_cyc = rel;
            end
            if (busy) busy_cnt++;
            if (err) err_seen = 1'b1;
            if (prev_stall) begin
                hold_samples++;
                if (!wr_vld || wr_addr != prev_addr || wr_data != prev_data) hold_viol++;
            end
            prev_stall = wr_vld && !wr_rdy;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return {86'd0, busy, done, err, rd_en, rd_addr, act_gelu, act_scale, act_dat_in,
                act_in_vld, wr_vld, wr_addr, wr_data};
    endfunction

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        busy_cnt     = 0;
        err_seen     = 1'b0;
        hold_samples = 0;
        hold_viol    = 0;
    endtask

    task automatic kick(int len, logic [15:0] src, logic [15:0] dst, logic [2:0] sc, logic g);
        @(posedge clk); #1;
        cfg_len      = 16'(len);
        cfg_src_base = src;
        cfg_dst_base = dst;
        cfg_scale    = sc;
        cfg_gelu     = g;
        start        = 1'b1;
        t0           = cyc;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_pass(int len, logic [15:0] src, logic [15:0] dst, logic [2:0] sc,
                            logic g, bit bp);
        int n;
        int rel;
        kick(len, src, dst, sc, g);
        n = 0;
        while (done_cnt == 0 && n < 600) begin
            rel    = cyc - t0;
            wr_rdy = !(bp && rel >= 10 && rel <= 30);
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        wr_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          len;
        logic [15:0] src;
        logic [15:0] dst;
        logic [2:0]  scale;
        logic        gelu;
        int          exp_done;
    } vec_t;

    task automatic check_pass(vec_t v, bit bp);
        logic [15:0] ea;
        chk("done_pulses", done_cnt, 1);
        if (!bp) chk("done_cycle", done_cyc, v.exp_done);
        chk("busy_cycles", busy_cnt, bp ? done_cyc : v.exp_done);
        chk("rd_count", rd_q.size(), v.len);
        for (int k = 0; k < rd_q.size() && k < v.len; k++) begin
            ea = v.src + 16'(k);
            chk("rd_addr", rd_q[k].addr, ea);
            if (!bp) chk("rd_cycle", rd_q[k].cyc, 1 + k);
        end
        chk("wr_count", wr_q.size(), v.len);
        for (int k = 0; k < wr_q.size() && k < v.len; k++) begin
            ea = v.dst + 16'(k);
            chk("wr_addr", wr_q[k].addr, ea);
            chk("wr_data", wr_q[k].data, xform(mkword(v.src + 16'(k)), v.scale, v.gelu));
            if (!bp) chk("wr_cycle", wr_q[k].cyc, 7 + k);
        end
        chk("err", err_seen, 0);
        chk("act_scale_hold", act_scale, v.scale);
        chk("act_gelu_hold", act_gelu, v.gelu);
    endtask

    vec_t vecs[4];
    vec_t vbp;
    vec_t vpost;

    initial begin
        vecs[0] = '{16, 16'h0100, 16'h0200, 3'd3, 1'b1, 23};
        vecs[1] = '{0,  16'h0010, 16'h0020, 3'd0, 1'b0, 2};
        vecs[2] = '{4,  16'hFFFE, 16'h0300, 3'd5, 1'b1, 11};
        vecs[3] = '{1,  16'h0050, 16'hFFFF, 3'd7, 1'b0, 8};
        vbp     = '{32, 16'h0400, 16'h0800, 3'd2, 1'b1, 0};
        vpost   = '{4,  16'h0040, 16'h0090, 3'd1, 1'b0, 11};

        rst_n = 1'b0; start = 1'b0; wr_rdy = 1'b1;
        cfg_src_base = '0; cfg_dst_base = '0; cfg_len = '0; cfg_scale = '0; cfg_gelu = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_outputs(), '0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 4; v++) begin
            run_pass(vecs[v].len, vecs[v].src, vecs[v].dst, vecs[v].scale, vecs[v].gelu, 1'b0);
            $display("pass len=%0d src=%h dst=%h done_cyc=%0d reads=%0d writes=%0d",
                     vecs[v].len, vecs[v].src, vecs[v].dst, done_cyc, rd_q.size(), wr_q.size());
            check_pass(vecs[v], 1'b0);
        end

        // Backpressure: wr_rdy low for cycles 10..30.
        run_pass(vbp.len, vbp.src, vbp.dst, vbp.scale, vbp.gelu, 1'b1);
        $display("backpressure pass done_cyc=%0d reads=%0d writes=%0d hold_samples=%0d",
                 done_cyc, rd_q.size(), wr_q.size(), hold_samples);
        check_pass(vbp, 1'b1);
        chk("hold_viol", hold_viol, 0);
        chk("hold_seen", hold_samples > 0, 1);
        if (rd_q.size() > 0) chk("issue_stalled", rd_q[$].cyc > 32, 1);

        // Reset in cycle 8 of a 16-word pass.
        kick(16, 16'h0100, 16'h0200, 3'd6, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk("midpass_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midpass_reset_outputs", all_outputs(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        repeat (12) @(posedge clk);
        #1;
        $display("post-reset idle writes=%0d busy_cycles=%0d", wr_q.size(), busy_cnt);
        chk("post_reset_writes", wr_q.size(), 0);
        chk("post_reset_busy", busy_cnt, 0);
        chk("post_reset_err", err, 0);
        run_pass(vpost.len, vpost.src, vpost.dst, vpost.scale, vpost.gelu, 1'b0);
        $display("fresh pass after reset done_cyc=%0d writes=%0d", done_cyc, wr_q.size());
        check_pass(vpost, 1'b0);

        // Overflow: no drain, slow datapath, then extra results forced in.
        model_lat = 12;
        wr_rdy    = 1'b0;
        kick(16, 16'h0500, 16'h0600, 3'd4, 1'b1);
        repeat (23) @(posedge clk);
        #1;
        chk("credit_limited_reads", rd_q.size(), 8);
        chk("err_before_inject", err, 0);
        inject_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inject_vld = 1'b0;
        chk("err_after_inject", err, 1);
        repeat (2) @(posedge clk);
        #1;
        cfg_src_base = 16'h7000;
        cfg_scale    = 3'd1;
        cfg_len      = 16'd2;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("overflow case err=%0b busy=%0b rd_addr=%h act_scale=%0d", err, busy, rd_addr, act_scale);
        chk("busy_start_ignored_busy", busy, 1);
        chk("busy_start_ignored_scale", act_scale, 3'd4);
        chk("busy_start_ignored_addr", rd_addr, 16'h0508);
        chk("busy_start_no_reads", rd_q.size(), 8);
        repeat (8) @(posedge clk);
        #1;
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        chk("err_cleared_by_reset", err, 0);
        model_lat = 4;
        wr_rdy    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (16) @(posedge clk);
        run_pass(vecs[0].len, vecs[0].src, vecs[0].dst, vecs[0].scale, vecs[0].gelu, 1'b0);
        $display("final pass done_cyc=%0d writes=%0d", done_cyc, wr_q.size());
        check_pass(vecs[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
